priority_req_capture: RTL and testbench
=======================================

// Module: priority_req_capture
// PURPOSE
//  Front-end stage that feeds tt_um_priority_encoder. Synchronises raw request pins into clk.
//  Debounces each request bit and turns each debounced rising edge into a sticky pending bit.
//  Presents the pending vector to the encoder; the encoder returns an ack with the index it
//  serviced, and this block then clears that bit. Overrun flags record requests lost while pending.
// PARAMETERS
//  WIDTH        8  number of request lines
//  IDX_W        3  ack index width; must equal clog2(WIDTH)
//  SYNC_STAGES  2  synchroniser flops per bit (>=2)
//  DB_CYCLES    4  consecutive mismatching cycles needed to accept a level change (1..15)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      asynchronous reset, active-high
//  ena          in   1      enable; low freezes debounce counters and edge capture
//  req_raw      in   WIDTH  asynchronous request pins (ui_in)
//  ack_valid    in   1      encoder serviced a request this cycle
//  ack_idx      in   IDX_W  index serviced; only meaningful when ack_valid=1
//  pending      out  WIDTH  sticky pending requests to encoder (registered)
//  pending_any  out  1      |pending (registered, same cycle as pending)
//  overrun      out  WIDTH  sticky: new edge arrived while that bit already pending
// BEHAVIOUR
//  - Reset: sync chain, db level, counters, pending, pending_any, overrun all 0.
//  - Reset mid-operation clears everything immediately. Captures in flight are discarded.
//  - Sync: req_raw[i] passes through SYNC_STAGES flops to give s[i]; the sync chain runs even when ena=0.
//  - Debounce per bit: a 4-bit counter cnt[i] holds the run length. Rules per edge:
//      s[i]==db[i]                        -> cnt<=0
//      s[i]!=db[i], cnt<DB_CYCLES-1       -> cnt<=cnt+1
//      s[i]!=db[i], cnt==DB_CYCLES-1      -> db<=s, cnt<=0
//    Glitches shorter than DB_CYCLES cycles never change db.
//  - Edge: rise[i] = db[i] goes 0->1 on this edge. Falling edges are ignored, apart from re-arming.
//  - Pending update on the next edge, per bit i:
//      clr = ack_valid & (ack_idx==i)
//      rise & !pending           -> pending<=1
//      rise &  pending & !clr    -> pending stays 1, overrun<=1
//      rise &  clr               -> pending stays 1 (set wins), no overrun
//      !rise & clr               -> pending<=0, overrun<=0
//  - ack_idx >= WIDTH, or an ack to a bit that is not pending: no effect.
//  - Latency: with defaults, req_raw rises and is held; pending[i] is high after 7 rising
//    edges (SYNC_STAGES + DB_CYCLES + 1).
//  - Ack to clear: pending drops 1 cycle after ack_valid. pending_any tracks pending in the same cycle.
//  - ena=0: counters hold, db holds, no rise events. Acks are still honoured.
//    When ena returns to 1, capture resumes using the current counter values.
// CONFIGURATION
//  PRIO_REQ_MASK_EN defined:
//    - Adds ports mask_wr (in,1) and mask_data (in,WIDTH), and an internal mask register.
//      The mask resets to all-ones and loads mask_data on the edge where mask_wr=1.
//    - pending output = pending_int & mask; pending_any = |(pending_int & mask).
//    - Masked bits still capture and flag overrun internally. They appear on pending once unmasked.
//  Not defined: mask ports are absent, and pending = pending_int.
// TESTING
//  1. rst=1, then release; hold req_raw=8'h00 -> pending=0, pending_any=0, overrun=0 for all cycles.
//  2. req_raw=8'h24, held -> pending=8'h24 exactly 7 edges later.
//     Then ack_idx=5 -> pending=8'h04; ack_idx=2 -> pending=0, pending_any=0.
//  3. 3-cycle pulse on req_raw[0] -> pending stays 0.
//     A 4-cycle pulse on req_raw[0] followed by 8 cycles low -> pending[0]=1.
//  4. bit 7 pending; toggle req_raw[7] low 6 cycles then high 6 cycles -> overrun=8'h80.
//     Then ack_idx=7 -> pending[7]=0 and overrun[7]=0.
//  5. Rise on bit 3 in the same cycle as ack_idx=3 -> pending[3] stays 1, overrun[3]=0.
//     ack_idx=3 while ena=0 -> pending[3]=0.
//  6. Assert rst for 1 cycle with pending=8'hFF mid-debounce -> all outputs 0 asynchronously.
//     (PRIO_REQ_MASK_EN) mask=8'h0F with pending_int=8'hFF -> pending=8'h0F.

Source files
------------

// File: rtl/priority_req_capture.sv
// priority_req_capture
//   Request front end for the priority encoder: synchronises the raw request
//   pins, debounces each line, converts debounced rising edges into sticky
//   pending bits, clears a bit when the encoder acks its index, and flags
//   overruns for requests that arrive while their bit is already pending.
//   Optional feature macro: PRIO_REQ_MASK_EN (adds a per-bit output mask).
module priority_req_capture #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned IDX_W       = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] req_raw,
   input  logic             ack_valid,
   input  logic [IDX_W-1:0] ack_idx,
`ifdef PRIO_REQ_MASK_EN
   input  logic             mask_wr,
   input  logic [WIDTH-1:0] mask_data,
`endif
   output logic [WIDTH-1:0] pending,
   output logic             pending_any,
   output logic [WIDTH-1:0] overrun
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] rise_q;
   logic [3:0]       cnt_q [WIDTH];
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pend_int_q;
   logic [WIDTH-1:0] pend_nxt;
   logic [WIDTH-1:0] ovr_nxt;
   logic [WIDTH-1:0] mask_nxt;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; runs regardless of ena
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= req_raw;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // Per-bit debounce; a registered rise pulse marks an accepted 0->1 change
   // so the pending update lands one edge after db changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q   <= '0;
         rise_q <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else if (ena) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s[i] == db_q[i]) begin
               cnt_q[i]  <= '0;
               rise_q[i] <= 1'b0;
            end else if (cnt_q[i] < 4'(DB_CYCLES - 1)) begin
               cnt_q[i]  <= cnt_q[i] + 4'd1;
               rise_q[i] <= 1'b0;
            end else begin
               db_q[i]   <= s[i];
               cnt_q[i]  <= '0;
               rise_q[i] <= s[i];
            end
         end
      end else begin
         rise_q <= '0;
      end
   end

   // Decode the ack into a per-bit clear request
   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         clr[i] = ack_valid && (ack_idx == IDX_W'(i));
   end

   // Next pending/overrun state; a rise coinciding with its own ack wins
   always_comb begin
      pend_nxt = pend_int_q;
      ovr_nxt  = overrun;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (rise_q[i]) begin
            if (pend_int_q[i] && !clr[i]) ovr_nxt[i] = 1'b1;
            pend_nxt[i] = 1'b1;
         end else if (clr[i]) begin
            pend_nxt[i] = 1'b0;
            ovr_nxt[i]  = 1'b0;
         end
      end
   end

`ifdef PRIO_REQ_MASK_EN
   logic [WIDTH-1:0] mask_q;

   assign mask_nxt = mask_wr ? mask_data : mask_q;

   // Output mask register, all lines visible after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mask_q <= '1;
      else     mask_q <= mask_nxt;
   end
`else
   assign mask_nxt = '1;
`endif

   // Pending/overrun state and registered outputs; the mask is applied to the
   // next-state value so pending and pending_any stay aligned with the mask
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_int_q  <= '0;
         pending     <= '0;
         pending_any <= 1'b0;
         overrun     <= '0;
      end else begin
         pend_int_q  <= pend_nxt;
         pending     <= pend_nxt & mask_nxt;
         pending_any <= |(pend_nxt & mask_nxt);
         overrun     <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_priority_req_capture.sv
// tb_priority_req_capture
//   Directed bench for priority_req_capture with default parameters
//   (WIDTH=8, IDX_W=3, SYNC_STAGES=2, DB_CYCLES=4). Inputs change on the
//   falling edge, outputs are sampled on the falling edge.
module tb_priority_req_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] req_raw;
   logic       ack_valid;
   logic [2:0] ack_idx;
   logic [7:0] pending;
   logic       pending_any;
   logic [7:0] overrun;
`ifdef PRIO_REQ_MASK_EN
   logic       mask_wr;
   logic [7:0] mask_data;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   priority_req_capture #(
      .WIDTH(8),
      .IDX_W(3),
      .SYNC_STAGES(2),
      .DB_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .req_raw(req_raw),
      .ack_valid(ack_valid),
      .ack_idx(ack_idx),
`ifdef PRIO_REQ_MASK_EN
      .mask_wr(mask_wr),
      .mask_data(mask_data),
`endif
      .pending(pending),
      .pending_any(pending_any),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack(input logic [2:0] idx);
      ack_valid = 1'b1;
      ack_idx   = idx;
      step(1);
      ack_valid = 1'b0;
      ack_idx   = '0;
   endtask

   initial begin
      rst       = 1'b1;
      ena       = 1'b1;
      req_raw   = 8'h00;
      ack_valid = 1'b0;
      ack_idx   = '0;
`ifdef PRIO_REQ_MASK_EN
      mask_wr   = 1'b0;
      mask_data = '0;
`endif

      // 1. reset state and idle
      step(2);
      check("reset_state", {15'd0, pending, pending_any, overrun}, 32'd0);
      rst = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         step(1);
         check("idle", {15'd0, pending, pending_any, overrun}, 32'd0);
      end

      // 2. latency of 7 edges, then ack 5 and ack 2
      req_raw = 8'h24;
      step(6);
      check("lat_edge6", {24'd0, pending}, 32'h00);
      step(1);
      check("lat_edge7", {24'd0, pending}, 32'h24);
      check("lat_any", {31'd0, pending_any}, 32'd1);
      ack(3'd5);
      check("ack5", {24'd0, pending}, 32'h04);
      ack(3'd2);
      check("ack2", {23'd0, pending, pending_any}, 32'd0);
      ack(3'd6);
      check("ack_not_pending", {15'd0, pending, pending_any, overrun}, 32'd0);

      // 3. glitch rejection and minimum accepted pulse on bit 0
      req_raw = 8'h25;
      step(3);
      req_raw = 8'h24;
      step(8);
      check("glitch3", {24'd0, pending}, 32'h00);
      req_raw = 8'h25;
      step(4);
      req_raw = 8'h24;
      step(8);
      check("pulse4", {24'd0, pending}, 32'h01);
      ack(3'd0);
      check("ack0", {16'd0, pending, overrun}, 32'd0);

      // 4. overrun on bit 7, cleared by its ack
      req_raw = 8'hA4;
      step(7);
      check("b7_pending", {24'd0, pending}, 32'h80);
      req_raw = 8'h24;
      step(6);
      req_raw = 8'hA4;
      step(6);
      check("b7_no_ovr_yet", {24'd0, overrun}, 32'h00);
      step(4);
      check("b7_overrun", {16'd0, pending, overrun}, 32'h8080);
      ack(3'd7);
      check("b7_ack", {16'd0, pending, overrun}, 32'h0000);

      // 5. rise on bit 3 coinciding with ack 3, then ack while disabled
      req_raw = 8'hAC;
      step(7);
      check("b3_pending", {24'd0, pending}, 32'h08);
      req_raw = 8'hA4;
      step(6);
      req_raw = 8'hAC;
      step(6);
      check("b3_pre", {16'd0, pending, overrun}, 32'h0800);
      ack(3'd3);
      check("b3_set_wins", {16'd0, pending, overrun}, 32'h0800);
      step(3);
      check("b3_settled", {16'd0, pending, overrun}, 32'h0800);
      ena = 1'b0;
      ack(3'd3);
      check("b3_ack_ena0", {23'd0, pending, pending_any}, 32'd0);
      req_raw = 8'h00;
      step(10);
      req_raw = 8'hAC;
      step(10);
      check("ena0_no_rise", {16'd0, pending, overrun}, 32'h0000);
      ena = 1'b1;

      // 6. all bits pending, asynchronous reset mid-debounce
      req_raw = 8'h00;
      step(8);
      req_raw = 8'hFF;
      step(7);
      check("all_pending", {23'd0, pending, pending_any}, {23'd0, 8'hFF, 1'b1});
`ifdef PRIO_REQ_MASK_EN
      mask_wr   = 1'b1;
      mask_data = 8'h0F;
      step(1);
      mask_wr   = 1'b0;
      check("mask_0f", {24'd0, pending}, 32'h0F);
`endif
      req_raw = 8'h00;
      step(3);
      #2 rst = 1'b1;
      #1 check("async_rst", {15'd0, pending, pending_any, overrun}, 32'd0);
      step(1);
      rst = 1'b0;
      step(10);
      check("post_rst", {15'd0, pending, pending_any, overrun}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
